// File: rtl/mux_8_1_if.sv
//------------------------------------------------------------------------------
// Module      : mux_8_1_if
// Description : Data/select/enable bundle and outputs of the 8:1 mux.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux_8_1_if;
  logic [7:0] in;
  logic [2:0] sel;
  logic       en;
  logic       y;
  logic [2:0] sel_q;
  logic       y_valid;

  modport master (output in, output sel, output en,
                  input  y,  input  sel_q, input y_valid);
  modport slave  (input  in, input  sel, input  en,
                  output y,  output sel_q, output y_valid);
endinterface

`default_nettype wire

// File: rtl/mux_8_1.sv
//------------------------------------------------------------------------------
// Module      : mux_8_1
// Description : 8:1 single-bit mux, optional output register, debug sel copy.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_8_1 #(
  parameter int   OUT_REG = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_8_1_if.slave   bus
);

  logic       w_y_next;
  logic [2:0] r_sel_q;
  logic       r_y_valid;

  assign w_y_next = bus.in[bus.sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q   <= 3'd0;
      r_y_valid <= 1'b0;
    end else if (bus.en) begin
      r_sel_q   <= bus.sel;
      r_y_valid <= 1'b1;
    end
  end

  assign bus.sel_q   = r_sel_q;
  assign bus.y_valid = r_y_valid;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic r_y;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_y <= RST_VAL;
        end else if (bus.en) begin
          r_y <= w_y_next;
        end
      end

      assign bus.y = r_y;
    end else begin : g_out_comb
      // Combinational mode: y ignores clk, en and reset entirely.
      assign bus.y = w_y_next;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mux_8_1.sv
//------------------------------------------------------------------------------
// Module      : tb_mux_8_1
// Description : Directed + exhaustive bench for mux_8_1, registered and comb.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_8_1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_8_1_if bus_r ();
  mux_8_1_if bus_c ();

  mux_8_1 #(.OUT_REG(1), .RST_VAL(1'b0)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_r.slave)
  );

  mux_8_1 #(.OUT_REG(0), .RST_VAL(1'b0)) u_dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: {y, sel_q} expected from the registered instance.
  logic [3:0] sb_q [$];
  logic       sweep_y [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic e);
    bus_r.in = d;  bus_r.sel = s;  bus_r.en = e;
    bus_c.in = d;  bus_c.sel = s;  bus_c.en = e;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_y"}, {7'd0, bus_r.y}, {7'd0, e[3]});
      check({tag, "_selq"}, {5'd0, bus_r.sel_q}, {5'd0, e[2:0]});
    end
  endtask

  initial begin
    logic [7:0] v;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive(8'hFF, 3'd7, 1'b1);
    #1 rst_n = 1'b0;

    // Held in reset with capture-worthy inputs.
    step();
    step();
    check("rst_y",      {7'd0, bus_r.y},       8'd0);
    check("rst_valid",  {7'd0, bus_r.y_valid}, 8'd0);
    check("rst_selq",   {5'd0, bus_r.sel_q},   8'd0);
    check("rst_comb_y", {7'd0, bus_c.y},       8'd1);
    check("rst_comb_v", {7'd0, bus_c.y_valid}, 8'd0);

    // Release between edges; first edge afterwards captures.
    rst_n = 1'b1;
    step();
    check("rel_y",      {7'd0, bus_r.y},       8'd1);
    check("rel_valid",  {7'd0, bus_r.y_valid}, 8'd1);
    check("rel_selq",   {5'd0, bus_r.sel_q},   8'd7);
    check("rel_comb_v", {7'd0, bus_c.y_valid}, 8'd1);

    // Sweep with fixed pattern, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      drive(8'b01110101, 3'(i), 1'b1);
      sb_q.push_back({sweep_y[i], 3'(i)});
      step();
      pop_check($sformatf("sweep%0d", i));
    end

    // Enable hold.
    drive(8'h01, 3'd0, 1'b1);
    sb_q.push_back({1'b1, 3'd0});
    step();
    pop_check("hold_cap");
    drive(8'h01, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_y",      {7'd0, bus_r.y},       8'd1);
      check("hold_selq",   {5'd0, bus_r.sel_q},   8'd0);
      check("hold_cselq",  {5'd0, bus_c.sel_q},   8'd0);
    end
    drive(8'h01, 3'd1, 1'b1);
    sb_q.push_back({1'b0, 3'd1});
    step();
    pop_check("hold_rel");

    // Mid-operation reset pulse shorter than a clock period.
    drive(8'h01, 3'd0, 1'b1);
    sb_q.push_back({1'b1, 3'd0});
    step();
    pop_check("mid_pre");
    #2 rst_n = 1'b0;
    #1;
    check("mid_y",      {7'd0, bus_r.y},       8'd0);
    check("mid_valid",  {7'd0, bus_r.y_valid}, 8'd0);
    check("mid_selq",   {5'd0, bus_r.sel_q},   8'd0);
    check("mid_comb_y", {7'd0, bus_c.y},       8'd1);
    #1 rst_n = 1'b1;
    sb_q.push_back({1'b1, 3'd0});
    step();
    pop_check("mid_post");
    check("mid_post_valid", {7'd0, bus_r.y_valid}, 8'd1);

    // Combinational instance responds without a clock edge.
    drive(8'b01110101, 3'd5, 1'b1);
    #1 check("comb_sel5", {7'd0, bus_c.y}, 8'd1);
    drive(8'b01110101, 3'd7, 1'b1);
    #1 check("comb_sel7", {7'd0, bus_c.y}, 8'd0);
    step();

    // Exhaustive: every data/select pair on both instances.
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 8; s++) begin
        v = 8'(d);
        drive(v, 3'(s), 1'b1);
        #1 check($sformatf("exh_comb_%0h_%0d", d, s), {7'd0, bus_c.y}, {7'd0, v[s]});
        sb_q.push_back({v[s], 3'(s)});
        step();
        pop_check($sformatf("exh_reg_%0h_%0d", d, s));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
